// File: rtl/ga23_sdr_arbiter_if.sv
// Bundle of layer-side and SDRAM-side signals around the GA23 tile-ROM arbiter.
// The master modport is the arbiter's view; slave is the layers/SDRAM side.
interface ga23_sdr_arbiter_if #(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32
);
    logic [NUM_LAYERS-1:0]        lyr_req;
    logic [NUM_LAYERS*ADDR_W-1:0] lyr_addr;
    logic [NUM_LAYERS*DATA_W-1:0] lyr_data;
    logic [NUM_LAYERS-1:0]        lyr_rdy;
    logic [ADDR_W-1:0]            sdr_addr;
    logic                         sdr_req;
    logic [DATA_W-1:0]            sdr_data;
    logic                         sdr_rdy;
    logic                         timeout_err;

    modport master (
        input  lyr_req, lyr_addr, sdr_data, sdr_rdy,
        output lyr_data, lyr_rdy, sdr_addr, sdr_req, timeout_err
    );

    modport slave (
        output lyr_req, lyr_addr, sdr_data, sdr_rdy,
        input  lyr_data, lyr_rdy, sdr_addr, sdr_req, timeout_err
    );
endinterface

// File: rtl/ga23_sdr_arbiter.sv
// Round-robin arbiter sharing one SDRAM read channel between NUM_LAYERS tile layers,
// with one pending slot per layer, a single access in flight and a WAIT timeout.
module ga23_sdr_arbiter #(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    ga23_sdr_arbiter_if.master   bus
);
    localparam int         PTR_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [NUM_LAYERS-1:0]   pend_r;
    logic [ADDR_W-1:0]       pend_addr_r [NUM_LAYERS];
    logic [DATA_W-1:0]       data_r      [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   rdy_r;
    logic [ADDR_W-1:0]       sdr_addr_r;
    logic                    sdr_req_r;
    logic                    timeout_err_r;
    logic [7:0]              tmo_cnt_r;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic [PTR_W-1:0]        cur_r;
    logic [PTR_W-1:0]        hi_idx_s;
    logic [PTR_W-1:0]        lo_idx_s;
    logic [PTR_W-1:0]        gnt_idx_s;
    logic [PTR_W-1:0]        next_ptr_s;
    logic                    hi_found_s;
    logic                    lo_found_s;
    logic                    any_pend_s;
    logic [ADDR_W-1:0]       gnt_addr_s;
    logic                    grant_s;
    logic                    complete_s;
    logic                    tmo_hit_s;

    // Rotating priority: first pending index at/after rr_ptr, else first one below it.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        gnt_addr_s = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hi_idx_s   = (pend_r[i] && (PTR_W'(i) >= rr_ptr_r) && !hi_found_s) ? PTR_W'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (pend_r[i] & (PTR_W'(i) >= rr_ptr_r));
            lo_idx_s   = (pend_r[i] && (PTR_W'(i) <  rr_ptr_r) && !lo_found_s) ? PTR_W'(i) : lo_idx_s;
            lo_found_s = lo_found_s | (pend_r[i] & (PTR_W'(i) <  rr_ptr_r));
        end
        any_pend_s = hi_found_s | lo_found_s;
        gnt_idx_s  = hi_found_s ? hi_idx_s : lo_idx_s;
        next_ptr_s = (gnt_idx_s == PTR_W'(NUM_LAYERS - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
        for (int i = 0; i < NUM_LAYERS; i++) begin
            gnt_addr_s = (PTR_W'(i) == gnt_idx_s) ? pend_addr_r[i] : gnt_addr_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and control strobes; a real completion beats the timeout on the same edge.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        complete_s   = 1'b0;
        tmo_hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_pend_s) begin
                    grant_s      = 1'b1;
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (bus.sdr_rdy) begin
                    complete_s   = 1'b1;
                    next_state_s = IDLE;
                end else if (tmo_cnt_r == TMO_LIM) begin
                    complete_s   = 1'b1;
                    tmo_hit_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Pending slots: a new request always wins over the clear from its own grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                pend_addr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (bus.lyr_req[i]) begin
                    pend_r[i]      <= 1'b1;
                    pend_addr_r[i] <= bus.lyr_addr[i*ADDR_W +: ADDR_W];
                end else if (grant_s && (gnt_idx_s == PTR_W'(i))) begin
                    pend_r[i] <= 1'b0;
                end else begin
                    pend_r[i] <= pend_r[i];
                end
            end
        end
    end

    // Grant bookkeeping, SDRAM strobe/address and the saturating WAIT counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdr_req_r     <= 1'b0;
            sdr_addr_r    <= '0;
            cur_r         <= '0;
            rr_ptr_r      <= '0;
            tmo_cnt_r     <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            sdr_req_r <= grant_s;
            if (grant_s) begin
                sdr_addr_r <= gnt_addr_s;
                cur_r      <= gnt_idx_s;
                rr_ptr_r   <= next_ptr_s;
                tmo_cnt_r  <= 8'd0;
            end else if ((state_r == WAIT) && (tmo_cnt_r != 8'hFF)) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // Per-layer returned row and one-cycle ready pulse; forced completions return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_r <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (complete_s && (cur_r == PTR_W'(i))) begin
                    rdy_r[i]  <= 1'b1;
                    data_r[i] <= tmo_hit_s ? '0 : bus.sdr_data;
                end else begin
                    rdy_r[i]  <= 1'b0;
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lyr_data
        assign bus.lyr_data[g*DATA_W +: DATA_W] = data_r[g];
    end

    assign bus.lyr_rdy     = rdy_r;
    assign bus.sdr_addr    = sdr_addr_r;
    assign bus.sdr_req     = sdr_req_r;
    assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Directed bench for ga23_sdr_arbiter: per-cycle vector table plus hand-written
// timeout, reset-during-access and completion-versus-timeout sequences.
module tb_ga23_sdr_arbiter;
    localparam int N   = 3;
    localparam int AW  = 22;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    ga23_sdr_arbiter_if #(.NUM_LAYERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ga23_sdr_arbiter #(.NUM_LAYERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [21:0] a0, a1, a2;
        logic        rdy;
        logic [31:0] sdata;
        logic        ereq;
        logic [21:0] eaddr;
        logic [2:0]  erdy;
        logic [31:0] edata;
        logic        eterr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] q, input logic [21:0] a0, input logic [21:0] a1,
                       input logic [21:0] a2, input logic rd, input logic [31:0] sd, input logic eq,
                       input logic [21:0] ea, input logic [2:0] er, input logic [31:0] ed, input logic et);
        vec_t t;
        t.rst = r; t.req = q; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.rdy = rd; t.sdata = sd;
        t.ereq = eq; t.eaddr = ea; t.erdy = er; t.edata = ed; t.eterr = et;
        vecs.push_back(t);
    endtask

    task automatic nop(input logic eq, input logic [21:0] ea);
        add(1'b0, 3'b000, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0, eq, ea, 3'b000, 32'h0, 1'b0);
    endtask

    task automatic ret(input logic [31:0] sd, input logic [2:0] er);
        add(1'b0, 3'b000, 22'h0, 22'h0, 22'h0, 1'b1, sd, 1'b0, 22'h0, er, sd, 1'b0);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int li);
        return bus.lyr_data[li*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int li;
        int n;
        int lat;
        int hits;

        reset        = 1'b1;
        bus.lyr_req  = '0;
        bus.lyr_addr = '0;
        bus.sdr_rdy  = 1'b0;
        bus.sdr_data = '0;

        // Reset then single request from layer 0, data four cycles after sdr_req.
        add(1'b1, 3'b000, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        add(1'b0, 3'b001, 22'h012340, 22'h0, 22'h0, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        nop(1'b1, 22'h012340);
        nop(1'b0, 22'h0); nop(1'b0, 22'h0); nop(1'b0, 22'h0);
        ret(32'hDEADBEEF, 3'b001);
        nop(1'b0, 22'h0);
        // Reset (rr_ptr back to 0), then all three layers at once, twice.
        add(1'b1, 3'b000, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        add(1'b0, 3'b111, 22'h000100, 22'h000200, 22'h000300, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        nop(1'b1, 22'h000100); nop(1'b0, 22'h0); ret(32'h11111111, 3'b001);
        nop(1'b1, 22'h000200); nop(1'b0, 22'h0); ret(32'h22222222, 3'b010);
        nop(1'b1, 22'h000300); nop(1'b0, 22'h0); ret(32'h33333333, 3'b100);
        add(1'b0, 3'b111, 22'h000400, 22'h000500, 22'h000600, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        nop(1'b1, 22'h000400); nop(1'b0, 22'h0); ret(32'h44444444, 3'b001);
        nop(1'b1, 22'h000500); ret(32'h55555555, 3'b010);
        nop(1'b1, 22'h000600); ret(32'h66666666, 3'b100);
        // Layer 1 overwrites its pending address while layer 0 is in flight.
        add(1'b0, 3'b001, 22'h000700, 22'h0, 22'h0, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        add(1'b0, 3'b010, 22'h0, 22'h0AAAAA, 22'h0, 1'b0, 32'h0, 1'b1, 22'h000700, 3'b000, 32'h0, 1'b0);
        add(1'b0, 3'b010, 22'h0, 22'h0BBBBB, 22'h0, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        ret(32'h77777777, 3'b001);
        nop(1'b1, 22'h0BBBBB); nop(1'b0, 22'h0); ret(32'h88888888, 3'b010);
        nop(1'b0, 22'h0); nop(1'b0, 22'h0);
        // Layer 2 requests again on its own grant edge.
        add(1'b0, 3'b100, 22'h0, 22'h0, 22'h0C0000, 1'b0, 32'h0, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        add(1'b0, 3'b100, 22'h0, 22'h0, 22'h0D0000, 1'b0, 32'h0, 1'b1, 22'h0C0000, 3'b000, 32'h0, 1'b0);
        ret(32'h99999999, 3'b100);
        nop(1'b1, 22'h0D0000); ret(32'hAAAAAAAA, 3'b100);
        nop(1'b0, 22'h0);
        // Stray completion strobe while idle is ignored.
        add(1'b0, 3'b000, 22'h0, 22'h0, 22'h0, 1'b1, 32'hCCCCCCCC, 1'b0, 22'h0, 3'b000, 32'h0, 1'b0);
        nop(1'b0, 22'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            reset        = vecs[k].rst;
            bus.lyr_req  = vecs[k].req;
            bus.lyr_addr = {vecs[k].a2, vecs[k].a1, vecs[k].a0};
            bus.sdr_rdy  = vecs[k].rdy;
            bus.sdr_data = vecs[k].sdata;
            @(posedge clk);
            #1;
            chk("sdr_req", k, 64'(bus.sdr_req), 64'(vecs[k].ereq));
            if (vecs[k].ereq) begin
                chk("sdr_addr", k, 64'(bus.sdr_addr), 64'(vecs[k].eaddr));
            end
            chk("lyr_rdy", k, 64'(bus.lyr_rdy), 64'(vecs[k].erdy));
            if (vecs[k].erdy != 3'b000) begin
                li = vecs[k].erdy[0] ? 0 : (vecs[k].erdy[1] ? 1 : 2);
                chk("lyr_data", k, 64'(lane(li)), 64'(vecs[k].edata));
            end
            if (vecs[k].rst) begin
                chk("rst_lyr_data", k, 64'(bus.lyr_data[63:0]), 64'h0);
                chk("rst_lyr_data_hi", k, 64'(bus.lyr_data[95:64]), 64'h0);
                chk("rst_sdr_addr", k, 64'(bus.sdr_addr), 64'h0);
            end
            chk("timeout_err", k, 64'(bus.timeout_err), 64'(vecs[k].eterr));
        end

        // Each layer keeps its last returned row.
        chk("held_l0", 0, 64'(lane(0)), 64'h77777777);
        chk("held_l1", 1, 64'(lane(1)), 64'h88888888);
        chk("held_l2", 2, 64'(lane(2)), 64'hAAAAAAAA);

        // Timeout: no response, forced completion 9 cycles after sdr_req.
        bus.lyr_req = 3'b001; bus.lyr_addr[21:0] = 22'h0E0000;
        tick();
        bus.lyr_req = 3'b000;
        n = 0;
        while (!bus.sdr_req && n < 10) begin tick(); n++; end
        chk("tmo_grant_lat", 0, 64'(n), 64'd1);
        chk("tmo_addr", 0, 64'(bus.sdr_addr), 64'h0E0000);
        lat = 0;
        while (bus.lyr_rdy == 3'b000 && lat < 20) begin tick(); lat++; end
        chk("tmo_lat", 0, 64'(lat), 64'd9);
        chk("tmo_rdy", 0, 64'(bus.lyr_rdy), 64'h1);
        chk("tmo_data", 0, 64'(lane(0)), 64'h0);
        chk("tmo_err", 0, 64'(bus.timeout_err), 64'h1);
        tick();
        chk("tmo_rdy_pulse", 0, 64'(bus.lyr_rdy), 64'h0);

        // Next access after a timeout completes normally; error stays sticky.
        bus.lyr_req = 3'b010; bus.lyr_addr[43:22] = 22'h0F0000;
        tick();
        bus.lyr_req = 3'b000;
        n = 0;
        while (!bus.sdr_req && n < 10) begin tick(); n++; end
        chk("post_tmo_addr", 0, 64'(bus.sdr_addr), 64'h0F0000);
        tick(); tick(); tick();
        bus.sdr_rdy = 1'b1; bus.sdr_data = 32'hBBBBBBBB;
        tick();
        bus.sdr_rdy = 1'b0;
        chk("post_tmo_rdy", 0, 64'(bus.lyr_rdy), 64'h2);
        chk("post_tmo_data", 0, 64'(lane(1)), 64'hBBBBBBBB);
        chk("post_tmo_err", 0, 64'(bus.timeout_err), 64'h1);

        // Reset in the middle of an access, then a stale completion strobe.
        tick();
        bus.lyr_req = 3'b001; bus.lyr_addr[21:0] = 22'h111111;
        tick();
        bus.lyr_req = 3'b000;
        tick();
        chk("mid_grant", 0, 64'(bus.sdr_req), 64'h1);
        tick();
        reset = 1'b1;
        #1;
        chk("async_rst_err", 0, 64'(bus.timeout_err), 64'h0);
        tick();
        chk("mid_rst_rdy", 0, 64'(bus.lyr_rdy), 64'h0);
        chk("mid_rst_req", 0, 64'(bus.sdr_req), 64'h0);
        chk("mid_rst_data", 0, 64'(bus.lyr_data[63:0]), 64'h0);
        chk("mid_rst_addr", 0, 64'(bus.sdr_addr), 64'h0);
        reset = 1'b0;
        bus.sdr_rdy = 1'b1; bus.sdr_data = 32'h12345678;
        tick();
        bus.sdr_rdy = 1'b0;
        hits = 0;
        for (int c = 0; c < 12; c++) begin
            hits += (bus.lyr_rdy != 3'b000 || bus.sdr_req) ? 1 : 0;
            tick();
        end
        chk("stale_activity", 0, 64'(hits), 64'd0);
        chk("stale_data", 0, 64'(bus.lyr_data[31:0]), 64'h0);

        // Completion on the timeout edge wins and leaves the error flag clear.
        bus.lyr_req = 3'b100; bus.lyr_addr[65:44] = 22'h222222;
        tick();
        bus.lyr_req = 3'b000;
        tick();
        chk("edge_grant", 0, 64'(bus.sdr_req), 64'h1);
        chk("edge_addr", 0, 64'(bus.sdr_addr), 64'h222222);
        for (int c = 0; c < 8; c++) begin
            tick();
        end
        chk("edge_no_early_rdy", 0, 64'(bus.lyr_rdy), 64'h0);
        bus.sdr_rdy = 1'b1; bus.sdr_data = 32'h5A5A5A5A;
        tick();
        bus.sdr_rdy = 1'b0;
        chk("edge_rdy", 0, 64'(bus.lyr_rdy), 64'h4);
        chk("edge_data", 0, 64'(lane(2)), 64'h5A5A5A5A);
        chk("edge_err", 0, 64'(bus.timeout_err), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
